usb_uart_ep_bridge: RTL and testbench

Byte-stream to USB bulk-endpoint bridge that sits between the user-facing serial pipe and the USB protocol engine's packet interfaces. Device-to-host bytes (uart_in) are buffered and packetized into IN packets. Packets close when MAX_PKT bytes are ready or after an idle flush timeout. Host-to-device bytes (OUT packets) are buffered and presented as a plain valid/ready byte stream (uart_out).

---
 rtl/usb_uart_ep_bridge.sv | 165 ++++++++++++++++
 tb/tb_usb_uart_ep_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_uart_ep_bridge.sv
// Byte-stream <-> USB bulk endpoint bridge: buffers uart_in into IN packets, OUT packets into uart_out.
// Optional macro USB_UART_LOOPBACK_EN adds a loopback port that routes OUT bytes back into the IN FIFO.
module usb_uart_ep_bridge #(
    parameter int FIFO_DEPTH   = 64,
    parameter int MAX_PKT      = 32,
    parameter int FLUSH_CYCLES = 48000
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       usb_configured,
`ifdef USB_UART_LOOPBACK_EN
    input  logic       loopback,
`endif
    input  logic [7:0] uart_in_data,
    input  logic       uart_in_valid,
    output logic       uart_in_ready,
    output logic [7:0] uart_out_data,
    output logic       uart_out_valid,
    input  logic       uart_out_ready,
    output logic [7:0] in_data,
    output logic       in_valid,
    output logic       in_last,
    input  logic       in_ready,
    input  logic [7:0] out_data,
    input  logic       out_valid,
    output logic       out_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAX_PKT + 1);
    localparam int TW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_PKT_C = CW'(MAX_PKT);
    localparam logic [LW-1:0] MAX_LEN_C = LW'(MAX_PKT);
    localparam logic [TW-1:0] FLUSH_C   = TW'(FLUSH_CYCLES);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_reg, state_next;
    logic [LW-1:0] pkt_len_reg, pkt_len_next;
    logic [LW-1:0] sent_cnt_reg, sent_cnt_next;
    logic [TW-1:0] timer_reg, timer_next;

    // FIFO index 0 carries device-to-host bytes, index 1 carries host-to-device bytes
    logic [1:0]         push, pop;
    logic [1:0][7:0]    din, head;
    logic [1:0][CW-1:0] count;
    logic               flush, in_full, out_full, lb_active, lb_move, in_pop;

`ifdef USB_UART_LOOPBACK_EN
    assign lb_active = loopback;
`else
    assign lb_active = 1'b0;
`endif

    assign flush    = !usb_configured;
    assign in_full  = (count[0] == DEPTH_C);
    assign out_full = (count[1] == DEPTH_C);
    assign lb_move  = lb_active && usb_configured && (count[1] != '0) && !in_full;

    assign uart_in_ready  = usb_configured && !in_full && !reset && !lb_active;
    assign out_ready      = !out_full && !reset;
    assign uart_out_valid = (count[1] != '0) && !lb_active;
    assign uart_out_data  = head[1];
    assign in_data        = head[0];

    assign push[0] = lb_active ? lb_move : (uart_in_valid && uart_in_ready);
    assign din[0]  = lb_active ? head[1] : uart_in_data;
    assign pop[0]  = in_pop;
    assign push[1] = out_valid && out_ready;
    assign din[1]  = out_data;
    assign pop[1]  = lb_active ? lb_move : (uart_out_valid && uart_out_ready);

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [7:0]    mem [FIFO_DEPTH];
        logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
        logic [CW-1:0] count_reg;

        always_ff @(posedge clk_48mhz) begin
            if (push[gi]) begin
                mem[wr_ptr_reg] <= din[gi];
            end
        end

        // Unconfigured device empties both directions; flush dominates push/pop
        always_ff @(posedge clk_48mhz or posedge reset) begin
            if (reset) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push[gi]) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                case ({push[gi], pop[gi]})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end

        assign head[gi]  = mem[rd_ptr_reg];
        assign count[gi] = count_reg;
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            pkt_len_reg  <= '0;
            sent_cnt_reg <= '0;
            timer_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pkt_len_reg  <= pkt_len_next;
            sent_cnt_reg <= sent_cnt_next;
            timer_reg    <= timer_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pkt_len_next  = pkt_len_reg;
        sent_cnt_next = sent_cnt_reg;
        timer_next    = timer_reg;
        in_valid      = (state_reg == SEND);
        in_last       = (state_reg == SEND) && (sent_cnt_reg == pkt_len_reg - LW'(1));
        in_pop        = in_valid && in_ready;

        if (push[0]) begin
            timer_next = '0;
        end else if (state_reg == IDLE && count[0] != '0 && timer_reg != FLUSH_C) begin
            timer_next = timer_reg + TW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (count[0] >= MAX_PKT_C || (count[0] != '0 && timer_reg == FLUSH_C)) begin
                    state_next    = SEND;
                    pkt_len_next  = (count[0] >= MAX_PKT_C) ? MAX_LEN_C : count[0][LW-1:0];
                    sent_cnt_next = '0;
                end
            end
            SEND: begin
                if (in_pop) begin
                    sent_cnt_next = sent_cnt_reg + LW'(1);
                    if (in_last) begin
                        state_next = IDLE;
                        timer_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Losing configuration aborts any packet in flight
        if (flush) begin
            state_next = IDLE;
            timer_next = '0;
        end
    end
endmodule

// File: tb/tb_usb_uart_ep_bridge.sv
// Directed self-checking bench for usb_uart_ep_bridge with a shortened flush timeout.
module tb_usb_uart_ep_bridge;
    localparam int FLUSH = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       usb_configured = 1'b0;
    logic [7:0] uart_in_data = 8'h00;
    logic       uart_in_valid = 1'b0;
    logic       uart_in_ready;
    logic [7:0] uart_out_data;
    logic       uart_out_valid;
    logic       uart_out_ready = 1'b0;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready = 1'b0;
    logic [7:0] out_data = 8'h00;
    logic       out_valid = 1'b0;
    logic       out_ready;

    int checks = 0;
    int failures = 0;
    logic [7:0] rx_q[$];
    bit         last_q[$];
    logic [7:0] out_q[$];

    always #5 clk = ~clk;

    usb_uart_ep_bridge #(.FIFO_DEPTH(64), .MAX_PKT(32), .FLUSH_CYCLES(FLUSH)) dut (
        .clk_48mhz(clk),
        .reset(reset),
        .usb_configured(usb_configured),
        .uart_in_data(uart_in_data),
        .uart_in_valid(uart_in_valid),
        .uart_in_ready(uart_in_ready),
        .uart_out_data(uart_out_data),
        .uart_out_valid(uart_out_valid),
        .uart_out_ready(uart_out_ready),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records transfers that the coming edge will complete, then advances one cycle
    task automatic step();
        if (in_valid && in_ready) begin
            rx_q.push_back(in_data);
            last_q.push_back(in_last);
            $display("IN  byte=%02h last=%0b", in_data, in_last);
        end
        if (uart_out_valid && uart_out_ready) begin
            out_q.push_back(uart_out_data);
            $display("OUT byte=%02h", uart_out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_in(input logic [7:0] b);
        int n = 0;
        uart_in_data  = b;
        uart_in_valid = 1'b1;
        while (!uart_in_ready && n < 100) begin
            step();
            n++;
        end
        check("push_in_ready", 32'(uart_in_ready), 1);
        step();
        uart_in_valid = 1'b0;
    endtask

    task automatic push_out(input logic [7:0] b);
        int n = 0;
        out_data  = b;
        out_valid = 1'b1;
        while (!out_ready && n < 100) begin
            step();
            n++;
        end
        check("push_out_ready", 32'(out_ready), 1);
        step();
        out_valid = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_q.size() < target && n < budget) begin
            step();
            n++;
        end
        check("wait_rx_count", 32'(rx_q.size()), 32'(target));
    endtask

    task automatic check_pkt_bytes(input string tag, input int base, input int idx,
                                   input logic [7:0] exp_b, input bit exp_last);
        if (rx_q.size() > base + idx) begin
            check({tag, "_data"}, 32'(rx_q[base+idx]), 32'(exp_b));
            check({tag, "_last"}, 32'(last_q[base+idx]), 32'(exp_last));
        end else begin
            check({tag, "_missing"}, 32'(rx_q.size()), 32'(base + idx + 1));
        end
    endtask

    initial begin
        string hello;
        int    n;
        int    base;
        int    obase;
        hello = "Hello World!\r\n";

        // Reset held with configured high: every handshake output must stay low
        usb_configured = 1'b1;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_in_ready", 32'(uart_in_ready), 0);
        check("rst_out_ready", 32'(out_ready), 0);
        check("rst_in_valid", 32'(in_valid), 0);
        check("rst_in_last", 32'(in_last), 0);
        check("rst_uart_out_valid", 32'(uart_out_valid), 0);
        reset = 1'b0;
        step();
        check("post_rst_uart_in_ready", 32'(uart_in_ready), 1);
        check("post_rst_out_ready", 32'(out_ready), 1);

        // Short packet released by the idle flush timeout
        in_ready = 1'b1;
        for (int i = 0; i < 14; i++) push_in(hello[i]);
        n = 0;
        while (!in_valid && n < 500) begin
            step();
            n++;
        end
        check("t1_flush_delay", 32'(n), 32'(FLUSH + 1));
        wait_rx(14, 100);
        for (int i = 0; i < 14; i++) check_pkt_bytes("t1", 0, i, hello[i], i == 13);
        check("t1_last_byte", 32'(rx_q[13]), 'h0A);
        check("t1_idle_after", 32'(in_valid), 0);

        // 40-byte stream: full packet then timed-out remainder
        base = rx_q.size();
        for (int i = 0; i < 40; i++) push_in(8'(8'h40 + i));
        wait_rx(base + 40, 500);
        for (int i = 0; i < 40; i++) check_pkt_bytes("t2", base, i, 8'(8'h40 + i), (i == 31) || (i == 39));
        check("t2_idle_after", 32'(in_valid), 0);

        // Fill the IN FIFO with the engine stalled
        in_ready = 1'b0;
        base = rx_q.size();
        for (int i = 0; i < 64; i++) push_in(8'(8'h80 + i));
        check("t3_full_ready", 32'(uart_in_ready), 0);
        check("t3_valid_stalled", 32'(in_valid), 1);
        uart_in_data  = 8'hEE;
        uart_in_valid = 1'b1;
        repeat (3) step();
        uart_in_valid = 1'b0;
        in_ready = 1'b1;
        wait_rx(base + 64, 300);
        for (int i = 0; i < 64; i++) check_pkt_bytes("t3", base, i, 8'(8'h80 + i), (i == 31) || (i == 63));
        repeat (FLUSH + 20) step();
        check("t3_no_extra_pkt", 32'(rx_q.size()), 32'(base + 64));

        // OUT path with the consumer stalled, then released
        uart_out_ready = 1'b0;
        push_out(8'h11);
        push_out(8'h22);
        push_out(8'h33);
        check("t4_out_valid", 32'(uart_out_valid), 1);
        check("t4_out_head", 32'(uart_out_data), 'h11);
        uart_out_ready = 1'b1;
        n = 0;
        while (out_q.size() < 3 && n < 50) begin
            step();
            n++;
        end
        check("t4_out_count", 32'(out_q.size()), 3);
        if (out_q.size() == 3) begin
            check("t4_out0", 32'(out_q[0]), 'h11);
            check("t4_out1", 32'(out_q[1]), 'h22);
            check("t4_out2", 32'(out_q[2]), 'h33);
        end
        check("t4_out_empty", 32'(uart_out_valid), 0);

        // Drop configuration in the middle of a packet
        uart_out_ready = 1'b0;
        in_ready = 1'b0;
        push_out(8'h55);
        push_out(8'h66);
        base  = rx_q.size();
        obase = out_q.size();
        for (int i = 0; i < 32; i++) push_in(8'(8'hA0 + i));
        in_ready = 1'b1;
        wait_rx(base + 5, 50);
        for (int i = 0; i < 5; i++) check_pkt_bytes("t5", base, i, 8'(8'hA0 + i), 1'b0);
        usb_configured = 1'b0;
        in_ready = 1'b0;
        check("t5_valid_same_cycle", 32'(in_valid), 1);
        step();
        check("t5_in_valid_dropped", 32'(in_valid), 0);
        check("t5_in_last", 32'(in_last), 0);
        check("t5_uart_in_ready", 32'(uart_in_ready), 0);
        check("t5_out_fifo_empty", 32'(uart_out_valid), 0);
        check("t5_out_ready", 32'(out_ready), 1);
        push_out(8'h77);
        check("t5_discarded", 32'(uart_out_valid), 0);
        usb_configured = 1'b1;
        uart_out_ready = 1'b1;
        in_ready = 1'b1;
        step();
        check("t5_reconf_ready", 32'(uart_in_ready), 1);
        repeat (FLUSH + 20) step();
        check("t5_in_fifo_empty", 32'(rx_q.size()), 32'(base + 5));
        check("t5_out_nothing", 32'(out_q.size()), 32'(obase));

        // Asynchronous reset mid-packet
        uart_out_ready = 1'b0;
        push_out(8'h99);
        in_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_in(8'(8'hC0 + i));
        n = 0;
        while (!in_valid && n < 300) begin
            step();
            n++;
        end
        check("t6_pkt_started", 32'(in_valid), 1);
        in_ready = 1'b1;
        repeat (2) step();
        #2 reset = 1'b1;
        #1;
        check("t6_rst_uart_in_ready", 32'(uart_in_ready), 0);
        check("t6_rst_out_ready", 32'(out_ready), 0);
        check("t6_rst_in_valid", 32'(in_valid), 0);
        check("t6_rst_in_last", 32'(in_last), 0);
        check("t6_rst_uart_out_valid", 32'(uart_out_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        base = rx_q.size();
        step();
        check("t6_post_in_valid", 32'(in_valid), 0);
        check("t6_post_out_empty", 32'(uart_out_valid), 0);
        check("t6_post_uart_in_ready", 32'(uart_in_ready), 1);
        repeat (FLUSH + 20) step();
        check("t6_in_fifo_empty", 32'(rx_q.size()), 32'(base));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
